// File: rtl/soric_bank_arbiter.sv
// Round-robin arbiter sharing one SoRIC bank among OBI-style masters.
// Define SORIC_ARB_HOST_PRIO_EN to give HOST_IDX absolute priority.
module soric_bank_arbiter #(
  parameter int MASTERS  = 4,
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int HOST_IDX = 2
) (
  input  logic                       clk,
  input  logic                       reset_ni,
  input  logic [MASTERS-1:0]         master_req_i,
  input  logic [MASTERS*ADDR_W-1:0]  master_addr_i,
  input  logic [MASTERS-1:0]         master_we_i,
  input  logic [MASTERS*DATA_W/8-1:0] master_be_i,
  input  logic [MASTERS*DATA_W-1:0]  master_wdata_i,
  output logic [MASTERS-1:0]         master_gnt_o,
  output logic [MASTERS-1:0]         master_rvalid_o,
  output logic [DATA_W-1:0]          master_rdata_o,
  output logic                       slave_req_o,
  output logic [ADDR_W-1:0]          slave_addr_o,
  output logic                       slave_we_o,
  output logic [DATA_W/8-1:0]        slave_be_o,
  output logic [DATA_W-1:0]          slave_wdata_o,
  input  logic                       slave_gnt_i,
  input  logic [DATA_W-1:0]          slave_rdata_i
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  if (HOST_IDX < 0 || HOST_IDX >= MASTERS) begin : g_bad_host
    $error("HOST_IDX out of range");
  end

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win;
  logic               found;
  logic               host_win;
  logic               any_req;
  logic               accept;
  logic [MASTERS-1:0] win_oh;
  logic [MASTERS-1:0] pipe [RD_LAT];
  int                 k;

  // Scan from rr_ptr upward, wrapping at MASTERS.
  always_comb begin
    win   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < MASTERS; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= MASTERS) k = k - MASTERS;
      if (!found && master_req_i[k]) begin
        found = 1'b1;
        win   = IDX_W'(k);
      end
    end
`ifdef SORIC_ARB_HOST_PRIO_EN
    host_win = master_req_i[HOST_IDX];
    if (host_win) win = IDX_W'(HOST_IDX);
`else
    host_win = 1'b0;
`endif
  end

  assign any_req = |master_req_i;
  assign accept  = reset_ni & any_req & slave_gnt_i;
  assign win_oh  = any_req ? (MASTERS'(1) << win) : '0;

  assign master_gnt_o  = accept ? win_oh : '0;
  assign slave_req_o   = reset_ni & any_req;
  assign slave_addr_o  = slave_req_o ? master_addr_i[win*ADDR_W +: ADDR_W] : '0;
  assign slave_we_o    = slave_req_o ? master_we_i[win] : 1'b0;
  assign slave_be_o    = slave_req_o ? master_be_i[win*BE_W +: BE_W] : '0;
  assign slave_wdata_o = slave_req_o ? master_wdata_i[win*DATA_W +: DATA_W] : '0;

  assign master_rvalid_o = reset_ni ? pipe[RD_LAT-1] : '0;
  assign master_rdata_o  = (|master_rvalid_o) ? slave_rdata_i : '0;

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      rr_ptr <= '0;
      for (int s = 0; s < RD_LAT; s++) pipe[s] <= '0;
    end else begin
      if (accept && !host_win)
        rr_ptr <= (win == IDX_W'(MASTERS - 1)) ? '0 : win + 1'b1;
      pipe[0] <= master_gnt_o;
      for (int s = 1; s < RD_LAT; s++) pipe[s] <= pipe[s-1];
    end
  end

endmodule

// File: tb/tb_soric_bank_arbiter.sv
// Randomized and directed bench for soric_bank_arbiter.
// Two instances (RD_LAT 1 and 2) share stimulus against one reference model.
module tb_soric_bank_arbiter;

  localparam int M    = 4;
  localparam int AW   = 11;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int HOST = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [M-1:0]  req;
  logic [M*AW-1:0] addr;
  logic [M-1:0]  we;
  logic [M*BW-1:0] be;
  logic [M*DW-1:0] wdata;
  logic          sgnt;
  logic [DW-1:0] srdata;

  logic [M-1:0]  gnt1, rv1, gnt2, rv2;
  logic [DW-1:0] rd1, rd2, swd1, swd2;
  logic          sreq1, sreq2, swe1, swe2;
  logic [AW-1:0] saddr1, saddr2;
  logic [BW-1:0] sbe1, sbe2;

  int n_chk = 0;
  int n_fail = 0;

  int ptr;
  logic [M-1:0] hist[$];

  always #5 clk = ~clk;

  soric_bank_arbiter #(.MASTERS(M), .ADDR_W(AW), .DATA_W(DW),
    .RD_LAT(1), .HOST_IDX(HOST)) dut1 (
    .clk(clk), .reset_ni(rst_n), .master_req_i(req),
    .master_addr_i(addr), .master_we_i(we), .master_be_i(be),
    .master_wdata_i(wdata), .master_gnt_o(gnt1),
    .master_rvalid_o(rv1), .master_rdata_o(rd1),
    .slave_req_o(sreq1), .slave_addr_o(saddr1), .slave_we_o(swe1),
    .slave_be_o(sbe1), .slave_wdata_o(swd1), .slave_gnt_i(sgnt),
    .slave_rdata_i(srdata));

  soric_bank_arbiter #(.MASTERS(M), .ADDR_W(AW), .DATA_W(DW),
    .RD_LAT(2), .HOST_IDX(HOST)) dut2 (
    .clk(clk), .reset_ni(rst_n), .master_req_i(req),
    .master_addr_i(addr), .master_we_i(we), .master_be_i(be),
    .master_wdata_i(wdata), .master_gnt_o(gnt2),
    .master_rvalid_o(rv2), .master_rdata_o(rd2),
    .slave_req_o(sreq2), .slave_addr_o(saddr2), .slave_we_o(swe2),
    .slave_be_o(sbe2), .slave_wdata_o(swd2), .slave_gnt_i(sgnt),
    .slave_rdata_i(srdata));

  function automatic int mwin();
    if (req == '0) return -1;
`ifdef SORIC_ARB_HOST_PRIO_EN
    if (req[HOST]) return HOST;
`endif
    for (int i = 0; i < M; i++)
      if (req[(ptr + i) % M]) return (ptr + i) % M;
    return -1;
  endfunction

  function automatic logic [M-1:0] mgnt();
    int w;
    w = mwin();
    if (!rst_n || !sgnt || w < 0) return '0;
    return M'(1) << w;
  endfunction

  function automatic logic [M-1:0] mrv(input int lat);
    if (!rst_n || hist.size() < lat) return '0;
    return hist[hist.size() - lat];
  endfunction

  task automatic tick();
    logic [M-1:0] g;
    int w;
    @(posedge clk);
    if (!rst_n) begin
      ptr = 0;
      hist.delete();
      hist.push_back('0);
    end else begin
      g = mgnt();
      w = mwin();
      if (g != '0) begin
`ifdef SORIC_ARB_HOST_PRIO_EN
        if (w != HOST) ptr = (w + 1) % M;
`else
        ptr = (w + 1) % M;
`endif
      end
      hist.push_back(g);
      if (hist.size() > 8) void'(hist.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    sgnt = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    sgnt = 1'b1;
    addr = {$urandom, $urandom};
    we = 4'b1111;
    be = 16'hffff;
    wdata = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) begin
      #1;
      n_chk++;
      if ({gnt1, sreq1, rv1, rv2, saddr1, swe1, sbe1, swd1} !== '0) begin
        n_fail++;
        $display("FAIL reset_outs got gnt=%b req=%b rv=%b/%b addr=%h we=%b be=%h wd=%h, need all 0",
          gnt1, sreq1, rv1, rv2, saddr1, swe1, sbe1, swd1);
      end
      tick();
    end
    rst_n = 1'b1;
    #1;
    n_chk++;
`ifdef SORIC_ARB_HOST_PRIO_EN
    if (gnt1 !== 4'b0100) begin
`else
    if (gnt1 !== 4'b0001) begin
`endif
      n_fail++;
      $display("FAIL reset_first_gnt got %b", gnt1);
    end
    tick();
    req = '0;
  endtask

  task automatic test_round_robin();
    logic [M-1:0] exp, prev;
    do_reset();
    req = 4'b1111;
    we = '0;
    prev = '0;
    for (int i = 0; i < 12; i++) begin
      srdata = $urandom;
`ifdef SORIC_ARB_HOST_PRIO_EN
      exp = 4'b0100;
`else
      exp = M'(1) << (i % M);
`endif
      #1;
      n_chk++;
      if (gnt1 !== exp || gnt2 !== exp) begin
        n_fail++;
        $display("FAIL rr_gnt cyc %0d got %b/%b need %b", i, gnt1, gnt2, exp);
      end
      n_chk++;
      if (rv1 !== prev || rd1 !== (prev != 0 ? srdata : '0)) begin
        n_fail++;
        $display("FAIL rr_rvalid cyc %0d got %b/%h need %b", i, rv1, rd1, prev);
      end
      n_chk++;
      if (rv2 !== mrv(2)) begin
        n_fail++;
        $display("FAIL rr_rvalid2 cyc %0d got %b need %b", i, rv2, mrv(2));
      end
      prev = exp;
      tick();
    end
    req = '0;
  endtask

  task automatic test_read();
    do_reset();
    req = 4'b0010;
    we = '0;
    addr[1*AW +: AW] = 11'h010;
    #1;
    n_chk++;
    if (gnt1 !== 4'b0010 || saddr1 !== 11'h010 || swe1 !== 1'b0) begin
      n_fail++;
      $display("FAIL read_req got gnt=%b addr=%h we=%b", gnt1, saddr1, swe1);
    end
    tick();
    req = '0;
    srdata = 32'hDEADBEEF;
    #1;
    n_chk++;
    if (rv1 !== 4'b0010 || rd1 !== 32'hDEADBEEF || rv2 !== 4'b0) begin
      n_fail++;
      $display("FAIL read_rsp got rv=%b rd=%h rv2=%b", rv1, rd1, rv2);
    end
    tick();
    #1;
    n_chk++;
    if (rv2 !== 4'b0010 || rd2 !== 32'hDEADBEEF || rv1 !== 4'b0) begin
      n_fail++;
      $display("FAIL read_rsp2 got rv2=%b rd2=%h rv1=%b", rv2, rd2, rv1);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [M-1:0] e0, e1;
    do_reset();
    req = 4'b0101;
    sgnt = 1'b0;
    repeat (4) begin
      #1;
      n_chk++;
      if (gnt1 !== 4'b0 || sreq1 !== 1'b1 || rv1 !== 4'b0) begin
        n_fail++;
        $display("FAIL stall got gnt=%b req=%b rv=%b", gnt1, sreq1, rv1);
      end
      tick();
    end
    sgnt = 1'b1;
`ifdef SORIC_ARB_HOST_PRIO_EN
    e0 = 4'b0100;
    e1 = 4'b0100;
`else
    e0 = 4'b0001;
    e1 = 4'b0100;
`endif
    #1;
    n_chk++;
    if (gnt1 !== e0) begin
      n_fail++;
      $display("FAIL stall_release0 got %b need %b", gnt1, e0);
    end
    tick();
    #1;
    n_chk++;
    if (gnt1 !== e1) begin
      n_fail++;
      $display("FAIL stall_release1 got %b need %b", gnt1, e1);
    end
    tick();
    req = '0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0010;
    tick();
    req = '0;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (rv1 !== 4'b0 || rv2 !== 4'b0) begin
      n_fail++;
      $display("FAIL midrst_in got %b/%b", rv1, rv2);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++;
      if (rv1 !== 4'b0 || rv2 !== 4'b0) begin
        n_fail++;
        $display("FAIL midrst_after cyc %0d got %b/%b", i, rv1, rv2);
      end
      tick();
    end
  endtask

`ifdef SORIC_ARB_HOST_PRIO_EN
  task automatic test_host_prio();
    logic [M-1:0] seq [3];
    seq[0] = 4'b0001;
    seq[1] = 4'b0010;
    seq[2] = 4'b1000;
    do_reset();
    req = 4'b1111;
    repeat (6) begin
      #1;
      n_chk++;
      if (gnt1 !== 4'b0100) begin
        n_fail++;
        $display("FAIL host_gnt got %b need 0100", gnt1);
      end
      tick();
    end
    req = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_chk++;
      if (gnt1 !== seq[i % 3]) begin
        n_fail++;
        $display("FAIL host_resume cyc %0d got %b need %b", i, gnt1, seq[i % 3]);
      end
      tick();
    end
    req = '0;
  endtask
`endif

  task automatic test_random();
    logic [M-1:0] eg;
    logic [AW-1:0] ea;
    logic ewe;
    logic [BW-1:0] ebe;
    logic [DW-1:0] ewd;
    int w;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 50) != 0);
      req = M'($urandom);
      sgnt = ($urandom_range(0, 3) != 0);
      addr = {$urandom, $urandom};
      we = M'($urandom);
      be = BW*M'($urandom);
      wdata = {$urandom, $urandom, $urandom, $urandom};
      srdata = $urandom;
      w = mwin();
      eg = mgnt();
      ea = '0; ewe = 1'b0; ebe = '0; ewd = '0;
      if (rst_n && w >= 0) begin
        ea = addr[w*AW +: AW];
        ewe = we[w];
        ebe = be[w*BW +: BW];
        ewd = wdata[w*DW +: DW];
      end
      #1;
      n_chk++;
      if (gnt1 !== eg || gnt2 !== eg || sreq1 !== (rst_n && w >= 0)) begin
        n_fail++;
        $display("FAIL rnd_gnt cyc %0d got %b/%b req=%b need %b", c, gnt1, gnt2, sreq1, eg);
      end
      n_chk++;
      if ({saddr1, swe1, sbe1, swd1} !== {ea, ewe, ebe, ewd}) begin
        n_fail++;
        $display("FAIL rnd_slave cyc %0d got %h %b %h %h need %h %b %h %h",
          c, saddr1, swe1, sbe1, swd1, ea, ewe, ebe, ewd);
      end
      n_chk++;
      if (rv1 !== mrv(1) || rv2 !== mrv(2) ||
          rd1 !== (mrv(1) != 0 ? srdata : '0) ||
          rd2 !== (mrv(2) != 0 ? srdata : '0)) begin
        n_fail++;
        $display("FAIL rnd_rsp cyc %0d got %b/%b %h/%h need %b/%b",
          c, rv1, rv2, rd1, rd2, mrv(1), mrv(2));
      end
      tick();
    end
    rst_n = 1'b1;
    req = '0;
  endtask

  initial begin
    ptr = 0;
    rst_n = 1'b0;
    req = '0;
    addr = '0;
    we = '0;
    be = '0;
    wdata = '0;
    sgnt = 1'b1;
    srdata = '0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_read();
    test_stall();
    test_mid_reset();
`ifdef SORIC_ARB_HOST_PRIO_EN
    test_host_prio();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/soric_bank_arbiter.md
Name: soric_bank_arbiter

Overview:
- Per-bank arbiter for one single-ported SRAM bank (or peripheral slave) in the SoRIC read/write fabric.
- Shares the bank among MASTERS OBI-style requesters (cores, Wishbone host, uart_to_mem) using round-robin.
- Drives the selected request to the bank and returns a one-hot rvalid with shared rdata after a fixed read latency.
- One instance per slave; slave_gnt_i allows a stalling peripheral.

Parameters:
- MASTERS, 4, number of requesters (2..8)
- ADDR_W, 11, bank word/byte address width
- DATA_W, 32, data width; byte enables are DATA_W/8
- RD_LAT, 1, cycles from accepted request to rvalid/rdata (1..3)
- HOST_IDX, 2, master index given absolute priority when SORIC_ARB_HOST_PRIO_EN is defined

Ports:
- clk  in  1  fabric clock
- reset_ni  in  1  synchronous active-low reset
- master_req_i  in  MASTERS  request per master
- master_addr_i  in  MASTERS*ADDR_W  packed addresses; master k at [k*ADDR_W +: ADDR_W]
- master_we_i  in  MASTERS  write enable
- master_be_i  in  MASTERS*DATA_W/8  byte enables
- master_wdata_i  in  MASTERS*DATA_W  write data
- master_gnt_o  out  MASTERS  one-hot grant, combinational
- master_rvalid_o  out  MASTERS  one-hot response valid
- master_rdata_o  out  DATA_W  response data, shared and qualified by rvalid
- slave_req_o  out  1  request to bank
- slave_addr_o  out  ADDR_W  winner address
- slave_we_o  out  1  winner write enable
- slave_be_o  out  DATA_W/8  winner byte enables
- slave_wdata_o  out  DATA_W  winner write data
- slave_gnt_i  in  1  bank accepts this cycle; tie high for SRAM
- slave_rdata_i  in  DATA_W  bank read data, valid RD_LAT cycles after acceptance

Behaviour:
- Reset (reset_ni low at a clk edge): rr_ptr=0; response pipeline cleared.
  - While reset_ni is low, master_gnt_o=0, slave_req_o=0 and master_rvalid_o=0.
  - slave_addr_o, slave_we_o, slave_be_o and slave_wdata_o are 0 during reset.
- Arbitration is combinational in the request cycle.
  - Winner = first requesting index scanning rr_ptr, rr_ptr+1, ... modulo MASTERS.
  - slave_req_o = |master_req_i. Slave data outputs mux the winner's fields; they are 0 when no request is present.
  - master_gnt_o[w] = slave_req_o & slave_gnt_i. All other grants are 0.
- Acceptance = slave_req_o & slave_gnt_i. On acceptance, rr_ptr <= (w+1) mod MASTERS. rr_ptr is unchanged otherwise.
- Stall: if slave_gnt_i=0, no grant and no pointer change. A master must hold its request; its inputs must stay stable.
- Response pipeline: an RD_LAT-deep shift register of {valid, one-hot winner}.
  - Loaded on acceptance for reads and writes alike; writes also produce exactly one rvalid.
  - master_rvalid_o = last stage. master_rdata_o = slave_rdata_i when any rvalid, otherwise 0.
  - Back-to-back acceptances produce back-to-back rvalids in acceptance order. Throughput is 1 request/cycle.
- Fairness: with all MASTERS requesting continuously, each master is granted exactly once every MASTERS accepted cycles.
- Single requester: granted every cycle, with no bubble.
- Reset mid-operation: in-flight responses are dropped; no rvalid appears after reset.
- A request dropped without a grant is legal and leaves no effect.

Optional Feature:
- SORIC_ARB_HOST_PRIO_EN defined:
  - If master_req_i[HOST_IDX] is high, HOST_IDX wins regardless of rr_ptr.
  - rr_ptr is not updated on host grants, so the remaining masters keep their round-robin order.
- Undefined: HOST_IDX is a normal round-robin participant. The HOST_IDX parameter is ignored.

Test Plan:
- Reset: hold reset_ni=0 for 3 cycles with master_req_i=4'b1111 -> master_gnt_o=0, slave_req_o=0, master_rvalid_o=0; first cycle after release grants master 0.
- All masters request continuously, slave_gnt_i=1, RD_LAT=1 -> grant order 0,1,2,3,0,...; master_rvalid_o is the previous cycle's master_gnt_o.
- Master 1 reads addr 11'h010 while bank rdata=32'hDEADBEEF -> gnt[1] in cycle T, rvalid[1] and master_rdata_o=32'hDEADBEEF in cycle T+1.
- slave_gnt_i=0 for 4 cycles with master_req_i=4'b0101 -> no grants, rr_ptr stable; after slave_gnt_i=1, master 0 is granted, then master 2.
- Reset asserted the cycle after an accepted read with RD_LAT=2 -> no rvalid is ever produced for it.
- With SORIC_ARB_HOST_PRIO_EN, master_req_i=4'b1111 held for 6 cycles -> master 2 granted all 6 cycles; after master 2 drops its request, the order resumes 0,1,3.
